aes_job_bridge: RTL and testbench

AES_JOB_BRIDGE -- requirements
Module: aes_job_bridge

---
 rtl/aes_job_bridge_pkg.sv | 21 ++
 rtl/aes_job_bridge_fifo.sv | 98 +++++++++
 rtl/aes_job_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_aes_job_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_job_bridge_pkg.sv
// Shared AES job types for the bridge and its FIFOs.
// Optional statistics counters are enabled with AES_JOB_BRIDGE_STATS_EN.
package AESDefinitions;

  localparam int STATE_W = 128;
  localparam int KEY_W   = 128;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [KEY_W-1:0]   key_t;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } job_mode_t;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/aes_job_bridge_fifo.sv
// Synchronous power-of-two FIFO. FWFT=1 shows the head word combinationally;
// FWFT=0 returns the popped word registered, with rd_valid pulsing one cycle later.
module aes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is legal when the same cycle frees a slot.
  assign do_wr = wr_en && (!full || do_rd);
  assign count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = mem_q[rd_ptr_q];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q, rd_valid_d;
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = do_rd;
        if (do_rd) begin
          rd_data_d = mem_q[rd_ptr_q];
        end
      end
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: rtl/aes_job_bridge.sv
// Credit-based job bridge between a request stream and an AES core, with in-order
// tag tracking and a result FIFO. Optional counters: AES_JOB_BRIDGE_STATS_EN.
module aes_job_bridge
  import AESDefinitions::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // depends on ready, and payload is held stable while valid && !ready.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  state_t           in_data,
  input  key_t             in_key,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic             core_valid,
  output logic             core_mode,
  output state_t           core_data,
  output key_t             core_key,
  input  state_t           core_result,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic             done,
  output logic [1:0]       state_dbg,
  output logic             err
`ifdef AES_JOB_BRIDGE_STATS_EN
  ,
  output logic [31:0]      stat_accepted,
  output logic [31:0]      stat_completed,
  output logic [31:0]      stat_stall
`endif
);

  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int TQ_W = TAG_W + 1;
  localparam int RF_W = STATE_W + TQ_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bridge_state_e;

  bridge_state_e state_q, state_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          core_valid_q, core_valid_d;
  job_mode_t     core_mode_q, core_mode_d;
  state_t        core_data_q, core_data_d;
  key_t          core_key_q, core_key_d;
  logic          err_q, err_d;
  logic          post_reset_q, post_reset_d;

  logic            accept, out_hs, core_done_eff, rf_wr;
  job_mode_t       acc_mode;
  logic [TQ_W-1:0] tq_head;
  logic            tq_valid;
  logic [CW-1:0]   inflight;
  logic [RF_W-1:0] rf_head;
  logic            rf_valid;
  logic [CW-1:0]   rf_count;

  assign acc_mode = job_mode_t'(in_mode);
  // The first cycle after reset release may still see a done from a flushed job.
  assign core_done_eff = core_done && !post_reset_q;
  assign rf_wr         = core_done_eff && tq_valid;
  assign out_hs        = rf_valid && out_ready;

  aes_sync_fifo #(.WIDTH(TQ_W), .DEPTH(FIFO_DEPTH), .FWFT(1'b1)) u_tag_q (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data ({in_tag, in_mode}),
    .rd_en   (core_done_eff),
    .rd_data (tq_head),
    .rd_valid(tq_valid),
    .count   (inflight)
  );

  aes_sync_fifo #(.WIDTH(RF_W), .DEPTH(FIFO_DEPTH), .FWFT(1'b1)) u_result_q (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rf_wr),
    .wr_data ({core_result, tq_head}),
    .rd_en   (out_ready),
    .rd_data (rf_head),
    .rd_valid(rf_valid),
    .count   (rf_count)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: in_ready = (credits_q != '0);
      S_DONE:        done     = 1'b1;
      default:       ;
    endcase
    accept = in_valid && in_ready;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DRAIN : S_RUN;
      S_RUN:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (inflight == '0 && rf_count == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, out_hs})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    core_valid_d = accept;
    core_mode_d  = core_mode_q;
    core_data_d  = core_data_q;
    core_key_d   = core_key_q;
    if (accept) begin
      core_mode_d = acc_mode;
      core_data_d = in_data;
      core_key_d  = in_key;
    end
    // A completion with no outstanding tag has nothing to pair with and is dropped.
    err_d        = err_q | (core_done_eff && !tq_valid);
    post_reset_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      credits_q    <= CW'(FIFO_DEPTH);
      core_valid_q <= 1'b0;
      core_mode_q  <= ENCRYPT;
      core_data_q  <= '0;
      core_key_q   <= '0;
      err_q        <= 1'b0;
      post_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      core_valid_q <= core_valid_d;
      core_mode_q  <= core_mode_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
      err_q        <= err_d;
      post_reset_q <= post_reset_d;
    end
  end

  assign core_valid = core_valid_q;
  assign core_mode  = core_mode_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

  // Stale FIFO storage is never visible: payload reads as zero when no result is held.
  assign out_valid = rf_valid;
  assign out_data  = rf_valid ? rf_head[RF_W-1 -: STATE_W] : '0;
  assign out_tag   = rf_valid ? rf_head[TAG_W:1] : '0;
  assign out_mode  = rf_valid ? rf_head[0] : 1'b0;

`ifdef AES_JOB_BRIDGE_STATS_EN
  logic [31:0] stat_accepted_q, stat_accepted_d;
  logic [31:0] stat_completed_q, stat_completed_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_accepted_d  = accept ? sat_inc32(stat_accepted_q) : stat_accepted_q;
    stat_completed_d = out_hs ? sat_inc32(stat_completed_q) : stat_completed_q;
    stat_stall_d     = (in_valid && !in_ready) ? sat_inc32(stat_stall_q) : stat_stall_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_accepted_q  <= '0;
      stat_completed_q <= '0;
      stat_stall_q     <= '0;
    end else begin
      stat_accepted_q  <= stat_accepted_d;
      stat_completed_q <= stat_completed_d;
      stat_stall_q     <= stat_stall_d;
    end
  end

  assign stat_accepted  = stat_accepted_q;
  assign stat_completed = stat_completed_q;
  assign stat_stall     = stat_stall_q;
`endif

endmodule

// File: tb/tb_aes_job_bridge.sv
// Directed bench for aes_job_bridge with a fixed-latency stub AES core that knows
// the FIPS-197 vector and otherwise returns data ^ key ^ {mode}.
module tb_aes_job_bridge;
  import AESDefinitions::*;

  localparam int DEPTH = 8;
  localparam int TW    = 4;
  localparam int SBW   = STATE_W + TW + 1;

  localparam state_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam state_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clock, reset;
  logic          in_valid, in_ready, in_mode, in_last;
  state_t        in_data;
  key_t          in_key;
  logic [TW-1:0] in_tag;
  logic          core_valid, core_mode, core_done;
  state_t        core_data, core_result;
  key_t          core_key;
  logic          out_valid, out_ready, out_mode;
  state_t        out_data;
  logic [TW-1:0] out_tag;
  logic          done, err;
  logic [1:0]    state_dbg;
`ifdef AES_JOB_BRIDGE_STATS_EN
  logic [31:0]   stat_accepted, stat_completed, stat_stall;
`endif

  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int popped = 0;
  int outstanding = 0;
  bit chk_credit = 0;
  bit toggle_en = 0;

  aes_job_bridge #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_key(in_key), .in_tag(in_tag), .in_last(in_last),
    .core_valid(core_valid), .core_mode(core_mode), .core_data(core_data),
    .core_key(core_key), .core_result(core_result), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_mode(out_mode),
    .done(done), .state_dbg(state_dbg), .err(err)
`ifdef AES_JOB_BRIDGE_STATS_EN
    , .stat_accepted(stat_accepted), .stat_completed(stat_completed), .stat_stall(stat_stall)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic state_t core_fn(input logic mode, input state_t d, input key_t k);
    if (k == FIPS_KEY && !mode && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && mode && d == FIPS_CT) return FIPS_PT;
    return d ^ k ^ {128{mode}};
  endfunction

  // stub core: three-stage pipeline, flushed by reset, plus an injection hook
  logic [2:0] pv;
  state_t     pr[3];
  logic       inj_done;
  always @(posedge clock) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], core_valid};
      pr[0] <= core_fn(core_mode, core_data, core_key);
      pr[1] <= pr[0];
      pr[2] <= pr[1];
    end
  end
  assign core_done   = pv[2] | inj_done;
  assign core_result = pr[2];

  task automatic check(input string tag, input logic [SBW-1:0] got, input logic [SBW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard monitor and outstanding-job tracker
  always @(negedge clock) begin
    if (!reset) begin
      if (chk_credit) begin
        check("credit_bound", outstanding <= DEPTH, 1);
        if (outstanding >= DEPTH) check("ready_at_zero_credit", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {out_data, out_tag, out_mode}, '0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_result", {out_data, out_tag, out_mode}, mon_e);
          popped++;
        end
      end
      if (in_valid && in_ready) outstanding++;
      if (out_valid && out_ready) outstanding--;
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (toggle_en) out_ready = ~out_ready;
    end
  end

  // driver tasks
  task automatic send(input logic [TW-1:0] tag, input logic mode, input state_t data,
                      input key_t key, input logic last);
    bit ok;
    @(posedge clock); #1;
    in_valid = 1'b1; in_tag = tag; in_mode = mode; in_data = data; in_key = key; in_last = last;
    ok = 0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({core_fn(mode, data, key), tag, mode});
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("core_valid", core_valid, 1);
    check("core_mode_data", {core_mode, core_data}, {mode, data});
    check("core_key", core_key, key);
    if (last) check("ready_in_drain", in_ready, 0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
    check("done_seen", ok, 1);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("state_back_idle", state_dbg, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    outstanding = 0;
  endtask

  initial begin : watchdog
    #400000;
    check("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  state_t snap;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_key = '0;
    in_tag = '0; in_last = 1'b0; out_ready = 1'b1; inj_done = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_core_valid", core_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_state", state_dbg, 0);
    check("rst_out_data", out_data, 0);

    // FIPS-197 encrypt, single-job stream from IDLE
    send(4'd3, 1'b0, FIPS_PT, FIPS_KEY, 1'b1);
    wait_done();

    // FIPS-197 decrypt
    send(4'd5, 1'b1, FIPS_CT, FIPS_KEY, 1'b1);
    wait_done();
    check("fips_all_out", exp_q.size(), 0);

    // back-pressure: eight jobs fill the credits, ninth must stall
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(TW'(i), 1'b0, {4{32'ha5a50000 | i}}, FIPS_KEY, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b1; in_tag = 4'd8; in_mode = 1'b0; in_data = {4{32'ha5a50008}}; in_last = 1'b1;
    repeat (8) @(negedge clock);
    check("held_accepted", outstanding, 8);
    check("held_in_ready", in_ready, 0);
    check("held_out_valid", out_valid, 1);
    check("held_head", {out_data, out_tag}, {({4{32'ha5a50000}} ^ FIPS_KEY), 4'd0});
    snap = out_data;
    repeat (5) @(negedge clock);
    check("held_stable", {out_data, out_tag, out_mode}, {snap, 4'd0, 1'b0});
    check("held_in_ready2", in_ready, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(4'd8, 1'b0, {4{32'ha5a50008}}, FIPS_KEY, 1'b1);
    wait_done();
    check("held_all_out", exp_q.size(), 0);

    // streaming with out_ready toggling every cycle
    popped = 0;
    chk_credit = 1;
    toggle_en = 1;
    for (int i = 0; i < 20; i++)
      send(TW'(i), i[0], {4{32'h10000000 + i}}, ~FIPS_KEY, i == 19);
    wait_done();
    toggle_en = 0;
    chk_credit = 0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("stream_count", popped, 20);
    check("stream_empty", exp_q.size(), 0);

    // spurious completion
    @(posedge clock); #1;
    inj_done = 1'b1;
    @(posedge clock); #1;
    inj_done = 1'b0;
    @(negedge clock);
    check("err_set", err, 1);
    check("err_no_out", out_valid, 0);
    repeat (5) @(negedge clock);
    check("err_sticky", err, 1);

    // reset with four jobs outstanding, done pulse right after release
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(TW'(i + 10), 1'b0, {4{32'hc0de0000 | i}}, FIPS_KEY, 1'b0);
    do_reset();
    inj_done = 1'b1;
    @(negedge clock);
    check("mid_rst_valids", {core_valid, out_valid, done, err}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_core", {core_mode, core_data}, 0);
    check("mid_rst_core_key", core_key, 0);
    check("mid_rst_out", {out_data, out_tag, out_mode}, 0);
    @(posedge clock); #1;
    inj_done = 1'b0;
    @(negedge clock);
    check("post_rst_done_ignored", err, 0);
    check("post_rst_no_out", out_valid, 0);
    out_ready = 1'b1;
    send(4'd9, 1'b0, FIPS_PT, FIPS_KEY, 1'b1);
    wait_done();
    check("final_empty", exp_q.size(), 0);
    check("final_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
